// File: rtl/styler_pkg.sv
// Shared constants, state encoding and byte-selection helpers for the styler host.
package styler_pkg;

  localparam logic [2:0] SEL_SCANLINE = 3'd0;
  localparam logic [2:0] SEL_CTRL     = 3'd1;
  localparam logic [2:0] SEL_BMP_LO   = 3'd2;
  localparam logic [2:0] SEL_BMP_HI   = 3'd3;
  localparam logic [2:0] SEL_ATTR0    = 3'd4;
  localparam logic [2:0] SEL_ATTR1    = 3'd5;
  localparam logic [2:0] SEL_ATTR2    = 3'd6;
  localparam logic [2:0] SEL_ATTR3    = 3'd7;

  localparam logic [7:0]  CTRL_RESET = 8'h3C;
  localparam int unsigned ATTR_W     = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } host_state_e;

  // Byte that the styler register at 'sel' must hold for the given job.
  function automatic logic [7:0] sel_byte(input logic [2:0]        sel,
                                          input logic [7:0]        ctrl,
                                          input logic [15:0]       bitmap,
                                          input logic [ATTR_W-1:0] attr,
                                          input logic [3:0]        scanline);
    logic [7:0] b;
    case (sel)
      SEL_CTRL:   b = ctrl;
      SEL_BMP_LO: b = bitmap[7:0];
      SEL_BMP_HI: b = bitmap[15:8];
      SEL_ATTR0:  b = attr[7:0];
      SEL_ATTR1:  b = attr[15:8];
      SEL_ATTR2:  b = attr[23:16];
      SEL_ATTR3:  b = {7'b0, attr[ATTR_W-1]};
      default:    b = {4'b0, scanline};
    endcase
    return b;
  endfunction

  // Write order is sel 1..7 then sel 0; returns the first pending sel in that order.
  function automatic logic [2:0] next_sel(input logic [7:0] mask);
    logic [2:0] s;
    logic       found;
    s     = SEL_SCANLINE;
    found = 1'b0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (mask[i] && !found) begin
        s     = 3'(i);
        found = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/styler_host_if.sv
// Request/response handshake bundle between the fetch pipeline (master) and styler_host (slave).
interface styler_host_if;
  import styler_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_ctrl;
  logic [15:0]       req_bitmap;
  logic [ATTR_W-1:0] req_attr;
  logic [3:0]        req_scanline;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_scanline;
  logic [15:0]       rsp_bitmap;

  modport master (
    output req_valid, req_ctrl, req_bitmap, req_attr, req_scanline, rsp_ready,
    input  req_ready, rsp_valid, rsp_scanline, rsp_bitmap
  );

  modport slave (
    input  req_valid, req_ctrl, req_bitmap, req_attr, req_scanline, rsp_ready,
    output req_ready, rsp_valid, rsp_scanline, rsp_bitmap
  );

endinterface

// File: rtl/styler_host_shadow.sv
// Shadow of the styler's ctrl/bitmap/attr registers; flags which sels of a new job differ.
// Only instantiated when STYLER_HOST_SKIP_EN is defined.
module styler_host_shadow
  import styler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_sel_i,
  input  logic [7:0]        wr_data_i,
  input  logic [7:0]        ctrl_i,
  input  logic [15:0]       bitmap_i,
  input  logic [ATTR_W-1:0] attr_i,
  output logic [7:0]        dirty_o
);

  logic [7:0] shd_q [1:7];
  logic       valid_q;

  // The shadow tracks writes as they complete; sel 0 always closes a write phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      for (int unsigned i = 1; i < 8; i++) shd_q[i] <= '0;
    end else if (wr_en_i) begin
      if (wr_sel_i == SEL_SCANLINE) valid_q <= 1'b1;
      else                          shd_q[wr_sel_i] <= wr_data_i;
    end
  end

  always_comb begin
    dirty_o = '1;
    for (int unsigned i = 1; i < 8; i++) begin
      dirty_o[i] = !valid_q ||
                   (sel_byte(3'(i), ctrl_i, bitmap_i, attr_i, 4'h0) != shd_q[i]);
    end
  end

endmodule

// File: rtl/styler_host.sv
// Bus-side sequencer: loads one job into the styler over its 8-bit bus and reads back the result.
// Optional STYLER_HOST_SKIP_EN skips rewriting registers whose value is unchanged.
module styler_host
  import styler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  styler_host_if.slave     host,
  input  logic             cursor_en,
  input  logic             blink_phase,
  input  logic             faint_phase,
  output logic [7:0]       bus_ui,
  output logic [7:0]       bus_uio,
  input  logic [7:0]       bus_uo,
  output logic             busy
);

  host_state_e       state_q, state_d;
  logic [7:0]        job_ctrl_q;
  logic [15:0]       job_bitmap_q;
  logic [ATTR_W-1:0] job_attr_q;
  logic [3:0]        job_scan_q;
  logic [7:0]        pend_q, pend_d;
  logic              wr_n_q, wr_n_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        uio_q, uio_d;
  logic [2:0]        phase_q;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic [3:0]        rsp_scan_q, rsp_scan_d;
  logic [15:0]       rsp_bmp_q, rsp_bmp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic [2:0]        nsel;
  logic [7:0]        dirty;

`ifdef STYLER_HOST_SKIP_EN
  styler_host_shadow u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (!wr_n_q),
    .wr_sel_i  (sel_q),
    .wr_data_i (uio_q),
    .ctrl_i    (host.req_ctrl),
    .bitmap_i  (host.req_bitmap),
    .attr_i    (host.req_attr),
    .dirty_o   (dirty)
  );
`else
  assign dirty = '1;
`endif

  // Bus outputs are computed one cycle ahead so the write/read of cycle T+1 is already on the pins.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    wr_n_d      = 1'b1;
    sel_d       = SEL_SCANLINE;
    uio_d       = '0;
    rd_idx_d    = rd_idx_q;
    rsp_scan_d  = rsp_scan_q;
    rsp_bmp_d   = rsp_bmp_q;
    rsp_valid_d = rsp_valid_q;
    accept      = 1'b0;
    nsel        = SEL_SCANLINE;
    unique case (state_q)
      ST_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          accept  = 1'b1;
          nsel    = next_sel(dirty);
          wr_n_d  = 1'b0;
          sel_d   = nsel;
          uio_d   = sel_byte(nsel, host.req_ctrl, host.req_bitmap, host.req_attr, host.req_scanline);
          pend_d  = dirty & ~(8'b1 << nsel);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (pend_q != '0) begin
          nsel   = next_sel(pend_q);
          wr_n_d = 1'b0;
          sel_d  = nsel;
          uio_d  = sel_byte(nsel, job_ctrl_q, job_bitmap_q, job_attr_q, job_scan_q);
          pend_d = pend_q & ~(8'b1 << nsel);
        end else begin
          rd_idx_d = 2'd0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        case (rd_idx_q)
          2'd0: begin
            rsp_scan_d = bus_uo[3:0];
            sel_d      = SEL_BMP_LO;
            rd_idx_d   = 2'd1;
          end
          2'd1: begin
            rsp_bmp_d[7:0] = bus_uo;
            sel_d          = SEL_BMP_HI;
            rd_idx_d       = 2'd2;
          end
          default: begin
            rsp_bmp_d[15:8] = bus_uo;
            rsp_valid_d     = 1'b1;
            state_d         = ST_RESP;
          end
        endcase
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      job_ctrl_q   <= '0;
      job_bitmap_q <= '0;
      job_attr_q   <= '0;
      job_scan_q   <= '0;
      pend_q       <= '0;
      wr_n_q       <= 1'b1;
      sel_q        <= SEL_SCANLINE;
      uio_q        <= '0;
      phase_q      <= '0;
      rd_idx_q     <= '0;
      rsp_scan_q   <= '0;
      rsp_bmp_q    <= '0;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      wr_n_q      <= wr_n_d;
      sel_q       <= sel_d;
      uio_q       <= uio_d;
      phase_q     <= {cursor_en, blink_phase, faint_phase};
      rd_idx_q    <= rd_idx_d;
      rsp_scan_q  <= rsp_scan_d;
      rsp_bmp_q   <= rsp_bmp_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      if (accept) begin
        job_ctrl_q   <= host.req_ctrl;
        job_bitmap_q <= host.req_bitmap;
        job_attr_q   <= host.req_attr;
        job_scan_q   <= host.req_scanline;
      end
    end
  end

  assign host.req_ready    = req_ready_q;
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_scanline = rsp_scan_q;
  assign host.rsp_bitmap   = rsp_bmp_q;
  assign bus_ui            = {wr_n_q, 1'b1, phase_q, sel_q};
  assign bus_uio           = uio_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_styler_host.sv
// Scoreboard bench for styler_host with a behavioural styler register model on the bus.
`timescale 1ns/1ps
module tb_styler_host;
  import styler_pkg::*;

`ifdef STYLER_HOST_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [3:0]       scan;
    logic [15:0]      bmp;
    int unsigned      rcyc;
    int unsigned      nw;
    logic [7:0][10:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cursor_en, blink_phase, faint_phase;
  logic [7:0] bus_ui, bus_uio, bus_uo;
  logic       busy;

  styler_host_if hif();

  styler_host dut (
    .clk         (clk),
    .rst         (rst),
    .host        (hif),
    .cursor_en   (cursor_en),
    .blink_phase (blink_phase),
    .faint_phase (faint_phase),
    .bus_ui      (bus_ui),
    .bus_uio     (bus_uio),
    .bus_uo      (bus_uo),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          rr_mode = 0;
  bit          started = 1'b0;
  exp_t        sb[$];
  logic [10:0] wlog[$];
  logic [7:0]  sreg [8];
  logic [7:0]  ref_shd [8];
  bit          ref_valid = 1'b0;
  logic [2:0]  ph_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Styler model: registers captured at the end of each write cycle, readback combinational in sel.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) sreg[i] <= (i == 1) ? CTRL_RESET : 8'h00;
    end else if (!bus_ui[7]) begin
      sreg[bus_ui[2:0]] <= bus_uio;
    end
  end

  always_comb begin
    case (bus_ui[2:0])
      3'd0:    bus_uo = {4'h0, sreg[0][3:0]};
      3'd2:    bus_uo = sreg[2] ^ 8'hAA;
      3'd3:    bus_uo = sreg[3] ^ 8'hAA;
      default: bus_uo = 8'h00;
    endcase
  end

  always @(posedge clk) if (!rst && !bus_ui[7]) wlog.push_back({bus_ui[2:0], bus_uio});

  always @(posedge clk) ph_exp <= rst ? 3'b000 : {cursor_en, blink_phase, faint_phase};

  initial begin
    cursor_en = 1'b0; blink_phase = 1'b0; faint_phase = 1'b0;
    forever begin
      @(posedge clk); #1;
      blink_phase = ~blink_phase;
      cursor_en   = 1'($urandom_range(0, 1));
      faint_phase = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    hif.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 1)      hif.rsp_ready = 1'b0;
      else if (rr_mode == 2) hif.rsp_ready = 1'b1;
      else                   hif.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: response timing, write sequence, payload, stability under backpressure, phase pass-through.
  logic        pv = 1'b0, pr = 1'b0;
  logic [3:0]  ps;
  logic [15:0] pb;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        if (started) chk("bus_ui_phase", {28'b0, bus_ui[6:3]}, {28'b0, 1'b1, ph_exp});
        if (pv && pr) begin
          chk("rsp_valid_drop", {31'b0, hif.rsp_valid}, 32'd0);
        end else if (hif.rsp_valid && !pv) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=valid expected=none cycle=%0d", cyc);
          end else begin
            e = sb[0];
            chk("rsp_cycle", cyc, e.rcyc);
            chk("nwrites", wlog.size(), e.nw);
            for (int i = 0; i < 8; i++)
              if (i < int'(e.nw) && i < wlog.size()) chk("write_sel_data", {21'b0, wlog[i]}, {21'b0, e.w[i]});
          end
          wlog.delete();
        end else if (hif.rsp_valid && pv && !pr) begin
          chk("hold_scanline", {28'b0, hif.rsp_scanline}, {28'b0, ps});
          chk("hold_bitmap", {16'b0, hif.rsp_bitmap}, {16'b0, pb});
        end
        if (hif.rsp_valid) begin
          chk("resp_req_ready", {31'b0, hif.req_ready}, 32'd0);
          chk("resp_bus_wr_n", {31'b0, bus_ui[7]}, 32'd1);
          chk("resp_bus_uio", {24'b0, bus_uio}, 32'd0);
        end
        if (hif.rsp_valid && hif.rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_scanline", {28'b0, hif.rsp_scanline}, {28'b0, e.scan});
          chk("rsp_bitmap", {16'b0, hif.rsp_bitmap}, {16'b0, e.bmp});
        end
        pv = hif.rsp_valid; pr = hif.rsp_ready;
        ps = hif.rsp_scanline; pb = hif.rsp_bitmap;
      end
    end
  end

  // Reference: registers 1..7 are rewritten only when they differ from what the styler last received.
  task automatic run_job(input logic [7:0] c, input logic [15:0] b,
                         input logic [ATTR_W-1:0] a, input logic [3:0] s);
    exp_t        e;
    logic [7:0]  bytes [8];
    logic [2:0]  sl;
    int unsigned n, waited;
    bytes[0] = {4'h0, s}; bytes[1] = c;
    bytes[2] = b[7:0];    bytes[3] = b[15:8];
    bytes[4] = a[7:0];    bytes[5] = a[15:8];
    bytes[6] = a[23:16];  bytes[7] = {7'b0, a[24]};
    n = 0;
    e.w = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      sl = (k == 7) ? 3'd0 : 3'(k + 1);
      if (sl == 3'd0 || !SKIP || !ref_valid || bytes[sl] != ref_shd[sl]) begin
        e.w[n] = {sl, bytes[sl]};
        n++;
      end
    end
    e.nw   = n;
    e.scan = s;
    e.bmp  = b ^ 16'hAAAA;
    @(posedge clk); #1;
    hif.req_ctrl = c; hif.req_bitmap = b; hif.req_attr = a; hif.req_scanline = s;
    hif.req_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!hif.req_ready && waited < 400);
    if (!hif.req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=0 expected=1 cycle=%0d", cyc);
      hif.req_valid = 1'b0;
      return;
    end
    e.rcyc = cyc + 1 + n + 3;
    sb.push_back(e);
    ref_valid = 1'b1;
    for (int i = 0; i < 8; i++) ref_shd[i] = bytes[i];
    @(posedge clk); #1;
    hif.req_valid    = 1'b0;
    hif.req_ctrl     = 8'($urandom);
    hif.req_bitmap   = 16'($urandom);
    hif.req_attr     = 25'($urandom);
    hif.req_scanline = 4'($urandom);
  endtask

  task automatic drain(input int unsigned lim);
    int unsigned n = 0;
    while ((sb.size() != 0 || hif.rsp_valid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 cycle=%0d", sb.size(), cyc);
    end
  endtask

  initial begin
    logic [7:0]        rc;
    logic [15:0]       rb;
    logic [ATTR_W-1:0] ra;
    logic [3:0]        rs;
    int unsigned       n;
    hif.req_valid = 1'b0; hif.req_ctrl = '0; hif.req_bitmap = '0;
    hif.req_attr = '0; hif.req_scanline = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_ui", {24'b0, bus_ui}, 32'hC0);
    chk("rst_bus_uio", {24'b0, bus_uio}, 32'h0);
    chk("rst_req_ready", {31'b0, hif.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, hif.rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_bitmap", {16'b0, hif.rsp_bitmap}, 32'd0);
    started = 1'b1;

    rr_mode = 2;
    run_job(8'h3C, 16'hA55A, 25'h1234567, 4'h5);
    drain(200);
    run_job(8'h3C, 16'hA55A, 25'h1234567, 4'h6);
    drain(200);

    rr_mode = 1;
    run_job(8'h12, 16'h1357, 25'h0ABCDEF, 4'h9);
    n = 0;
    while (!hif.rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", {31'b0, hif.rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    rr_mode = 2;
    drain(200);

    run_job(8'h81, 16'h2468, 25'h1F0E0D0, 4'h3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    wlog.delete();
    ref_valid = 1'b0;
    @(negedge clk);
    chk("midrst_bus_ui", {24'b0, bus_ui}, 32'hC0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_req_ready", {31'b0, hif.req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, hif.rsp_valid}, 32'd0);
    run_job(8'h81, 16'h2468, 25'h1F0E0D0, 4'h3);
    drain(200);

    rr_mode = 0;
    rc = 8'h81; rb = 16'h2468; ra = 25'h1F0E0D0; rs = 4'h3;
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 1) != 0) rc = 8'($urandom);
      if ($urandom_range(0, 1) != 0) rb = 16'($urandom);
      if ($urandom_range(0, 1) != 0) ra = 25'($urandom);
      rs = 4'($urandom);
      run_job(rc, rb, ra, rs);
    end
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/styler_host.md
# styler_host

Bus-side sequencer for the character styler. It accepts one character-cell job per request: ctrl, bitmap, attributes and scanline. It drives the styler's 8-bit register bus to load the job, reads back the styled scanline and bitmap, and returns them on a valid/ready response port. It sits between the text-mode fetch pipeline and the styler pins (ui_in / uio_in / uo_out).

## Interface
- No parameters.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  job offered.
- req_ready  out  1  high only in IDLE.
- req_ctrl  in  8  styler ctrl register value.
- req_bitmap  in  16  glyph row bitmap.
- req_attr  in  25  style attributes.
- req_scanline  in  4  scanline number.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_scanline  out  4  styler scanlineOut.
- rsp_bitmap  out  16  styler bitmapOut.
- cursor_en, blink_phase, faint_phase  in  1 each  phase inputs, forwarded to the bus.
- bus_ui  out  8  drives styler ui_in: [7]=wr_n, [6]=1 (uio stays input), [5]=cursor_en, [4]=blink_phase, [3]=faint_phase, [2:0]=sel.
- bus_uio  out  8  write data to the styler's uio_in.
- bus_uo  in  8  read data from the styler's uo_out (combinational in sel).
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On the req_valid&&req_ready edge, latch all req_* fields and go to WRITE.
- WRITE: one styler register per cycle, in fixed order sel 1 (ctrl), 2 (bitmap[7:0]), 3 (bitmap[15:8]), 4 (attr[7:0]), 5 (attr[15:8]), 6 (attr[23:16]), 7 ({7'b0,attr[24]}), 0 ({4'b0,scanline}).
  - In each write cycle: bus_ui[7]=0, bus_ui[2:0]=sel, bus_uio=data.
- READ: three cycles with bus_ui[7]=1, sel=0, then 2, then 3.
  - At the end of each cycle, sample bus_uo into rsp_scanline=bus_uo[3:0], then rsp_bitmap[7:0], then rsp_bitmap[15:8].
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On the handshake edge, return to IDLE.
- No request is accepted in the handshake cycle; the next acceptance happens at the earliest one cycle later.
- Outputs outside WRITE/READ: bus_ui[7]=1, sel=0, bus_uio=0.
- bus_ui[5:3] are registered copies of the phase inputs (1-cycle delay), updated every cycle in every state, independent of the FSM.

## Timing
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_scanline=0, rsp_bitmap=0, bus_ui=8'hC0, bus_uio=0, busy=0. The shadow valid flag is cleared.
- Cycle numbering: acceptance at edge T; cycle T+k is the cycle following edge T+k-1.
- Without skipping:
  - Writes occupy cycles T+1..T+8.
  - Reads occupy T+9..T+11.
  - rsp_valid asserts in cycle T+12.
- The styler captures each write at the end of its cycle, so the first read cycle sees fully updated outputs; no settle cycle is needed.
- Backpressure: while rsp_valid && !rsp_ready, the bus stays idle and req_ready=0.
- Reset mid-operation:
  - Abort at the next edge; all outputs take their reset values.
  - The styler must be reset by the same system reset.
- req_* changes after acceptance have no effect.

## Configuration
- STYLER_HOST_SKIP_EN defined:
  - Keep shadow copies of the last ctrl, bitmap and attr bytes written, plus a shadow valid flag.
  - A write for sel 1..7 is skipped, consuming no cycle, when the shadow is valid and the byte equals the shadow.
  - sel 0 is always written.
  - The shadow valid flag sets after the first completed WRITE phase.
  - Minimum latency: rsp_valid in cycle T+5.
- Not defined: all 8 writes are always issued; fixed latency of T+12.

## Structure
- Shared package styler_pkg holds:
  - The SEL_SCANLINE=0, SEL_CTRL=1, SEL_BMP_LO=2, SEL_BMP_HI=3, SEL_ATTR0..SEL_ATTR3=4..7 constants.
  - CTRL_RESET=8'h3C.
  - ATTR_W=25.
  - The host state enum.
- One sub-module: styler_host_shadow (shadow registers, valid flag, per-sel dirty mask), instantiated only under STYLER_HOST_SKIP_EN.

## Test plan
- Assert rst for 2 cycles -> bus_ui=8'hC0, bus_uio=0, req_ready=1, rsp_valid=0, busy=0.
- Job ctrl=8'h3C, bitmap=16'hA55A, attr=25'h1234567, scanline=4'h5, macro off -> writes sel/data 1/3C, 2/5A, 3/A5, 4/67, 5/45, 6/23, 7/01, 0/05 in cycles T+1..T+8; the bench model returns scanline 5 and bitmap 16'h0FF0 -> rsp_valid in cycle T+12 with rsp_scanline=5, rsp_bitmap=16'h0FF0.
- Macro on: repeat the same job with scanline=4'h6 -> only the sel 0 write (data 06) is issued; rsp_valid in cycle T+5.
- Hold rsp_ready low for 5 cycles -> rsp_* stable, req_ready=0, bus_ui[7]=1 throughout; rsp_valid falls on the edge where rsp_ready=1.
- Assert rst during the 4th write cycle -> next cycle bus_ui=8'hC0; the following job (macro on) issues all 8 writes.
- Toggle blink_phase each cycle while a job runs -> bus_ui[4] follows with a 1-cycle delay in every state.
